gray_code_conv_pipe: RTL and testbench

Parametrised, pipelined Gray/binary code converter with a valid/ready handshake on both sides.
- Each accepted word is converted in the direction selected by its own MODE bit: Gray->binary or binary->Gray.
- Includes an optional Gray-step checker that flags accepted Gray words differing from the previous Gray word in more than one bit.
- Used in the async FIFO and pointer paths wherever a converted pointer must be registered and checked rather than decoded combinationally.

---
 rtl/gray_code_conv_pipe.sv | 142 ++++++++++++++
 tb/tb_gray_code_conv_pipe.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gray_code_conv_pipe.sv
// Pipelined Gray<->binary converter with valid/ready handshaking on both sides
// and an optional checker that flags multi-bit steps between accepted Gray words.
module gray_code_conv_pipe #(
  parameter int WIDTH    = 5,
  parameter int STAGES   = 2,
  parameter bit CHECK_EN = 1
) (
  input  logic             CLK_i,
  input  logic             RST_i,
  input  logic             IN_VALID_i,
  output logic             IN_READY_o,
  input  logic             MODE_i,
  input  logic [WIDTH-1:0] DATA_i,
  output logic             OUT_VALID_o,
  input  logic             OUT_READY_i,
  output logic [WIDTH-1:0] DATA_o,
  output logic             MODE_o,
  input  logic             CHK_CLR_i,
  output logic             STEP_ERR_o,
  output logic [7:0]       ERR_CNT_o
);

  logic [WIDTH-1:0] conv_next;
  logic             accept;
  logic [STAGES:0]  ready;
  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] stage_mode;
  logic [WIDTH-1:0]  stage_data [STAGES];

  always_comb begin
    conv_next = '0;
    if (MODE_i) begin
      conv_next = DATA_i ^ (DATA_i >> 1);
    end else begin
      conv_next[WIDTH-1] = DATA_i[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
        conv_next[i] = conv_next[i+1] ^ DATA_i[i];
      end
    end
  end

  // A slot can take a new word when it is empty or its own word moves on.
  always_comb begin
    ready = '0;
    ready[STAGES] = OUT_READY_i;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ready[k] = !stage_valid[k] || ready[k+1];
    end
  end

  assign accept     = IN_VALID_i && ready[0];
  assign IN_READY_o = ready[0];

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      logic             src_valid;
      logic             src_mode;
      logic [WIDTH-1:0] src_data;
      logic             valid_reg;
      logic             mode_reg;
      logic [WIDTH-1:0] data_reg;

      if (gi == 0) begin : g_head
        assign src_valid = IN_VALID_i;
        assign src_mode  = MODE_i;
        assign src_data  = conv_next;
      end else begin : g_body
        assign src_valid = stage_valid[gi-1];
        assign src_mode  = stage_mode[gi-1];
        assign src_data  = stage_data[gi-1];
      end

      always_ff @(posedge CLK_i) begin
        if (RST_i) begin
          valid_reg <= 1'b0;
          mode_reg  <= 1'b0;
          data_reg  <= '0;
        end else if (ready[gi]) begin
          valid_reg <= src_valid;
          if (src_valid) begin
            mode_reg <= src_mode;
            data_reg <= src_data;
          end
        end
      end

      assign stage_valid[gi] = valid_reg;
      assign stage_mode[gi]  = mode_reg;
      assign stage_data[gi]  = data_reg;
    end
  endgenerate

  assign OUT_VALID_o = stage_valid[STAGES-1];
  assign MODE_o      = stage_mode[STAGES-1];
  assign DATA_o      = stage_data[STAGES-1];

  generate
    if (CHECK_EN) begin : g_checker
      logic             have_prev_reg;
      logic [WIDTH-1:0] prev_gray_reg;
      logic             step_err_reg;
      logic [7:0]       err_cnt_reg;
      logic [WIDTH-1:0] diff;
      logic             violation;

      // x & (x-1) is non-zero exactly when x has two or more bits set.
      assign diff      = DATA_i ^ prev_gray_reg;
      assign violation = accept && !MODE_i && have_prev_reg
                         && ((diff & (diff - WIDTH'(1))) != '0);

      always_ff @(posedge CLK_i) begin
        if (RST_i) begin
          have_prev_reg <= 1'b0;
          prev_gray_reg <= '0;
          step_err_reg  <= 1'b0;
          err_cnt_reg   <= 8'd0;
        end else begin
          if (accept && !MODE_i) begin
            prev_gray_reg <= DATA_i;
            have_prev_reg <= 1'b1;
          end
          if (CHK_CLR_i) begin
            step_err_reg <= violation;
            err_cnt_reg  <= {7'd0, violation};
          end else if (violation) begin
            step_err_reg <= 1'b1;
            if (err_cnt_reg != 8'hFF) begin
              err_cnt_reg <= err_cnt_reg + 8'd1;
            end
          end
        end
      end

      assign STEP_ERR_o = step_err_reg;
      assign ERR_CNT_o  = err_cnt_reg;
    end else begin : g_no_checker
      assign STEP_ERR_o = 1'b0;
      assign ERR_CNT_o  = 8'd0;
    end
  endgenerate

endmodule

// File: tb/tb_gray_code_conv_pipe.sv
// Self-checking bench for gray_code_conv_pipe: vector table, directed corner
// sequences and a randomized run against a word-level scoreboard model.
module tb_gray_code_conv_pipe;
  localparam int WIDTH  = 5;
  localparam int STAGES = 2;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, mode_in, out_valid, out_ready;
  logic             mode_out, chk_clr, step_err;
  logic [WIDTH-1:0] data_in, data_out;
  logic [7:0]       err_cnt;

  always #5 clk = ~clk;

  gray_code_conv_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .CHECK_EN(1'b1)) dut (
    .CLK_i(clk), .RST_i(rst), .IN_VALID_i(in_valid), .IN_READY_o(in_ready),
    .MODE_i(mode_in), .DATA_i(data_in), .OUT_VALID_o(out_valid),
    .OUT_READY_i(out_ready), .DATA_o(data_out), .MODE_o(mode_out),
    .CHK_CLR_i(chk_clr), .STEP_ERR_o(step_err), .ERR_CNT_o(err_cnt)
  );

  typedef struct {
    logic             m;
    logic [WIDTH-1:0] d;
    int               c;
  } word_t;

  typedef struct {
    logic             mode;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dexp;
  } vec_t;

  int errors = 0, checks = 0, cycle = 0, n_out = 0;
  word_t exp_q[$];
  logic [WIDTH-1:0] m_prev;
  bit m_have, m_err;
  int m_cnt;
  bit stall_prev;
  logic [WIDTH-1:0] stall_data;
  logic stall_mode;
  logic s_out_valid, s_mode, s_in_ready, s_step_err;
  logic [WIDTH-1:0] s_data;
  logic [7:0] s_err_cnt;
  bit last_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Binary value whose Gray code is g: XOR of all right shifts of g.
  function automatic logic [WIDTH-1:0] ref_g2b(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b = '0;
    for (int s = 0; s < WIDTH; s++) b ^= g >> s;
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] ref_b2g(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int hamming(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n = 0;
    for (int i = 0; i < WIDTH; i++) if (a[i] != b[i]) n++;
    return n;
  endfunction

  // One clock cycle: sample at negedge, compare, update the model, advance.
  task automatic tick();
    bit viol;
    word_t w;
    @(negedge clk);
    cycle++;
    viol = 0;
    last_acc = 0;
    s_out_valid = out_valid; s_data = data_out; s_mode = mode_out;
    s_in_ready = in_ready; s_step_err = step_err; s_err_cnt = err_cnt;
    check("step_err", step_err, m_err);
    check("err_cnt", err_cnt, m_cnt);
    if (stall_prev) begin
      check("stall_valid", out_valid, 1);
      check("stall_data", data_out, stall_data);
      check("stall_mode", mode_out, stall_mode);
    end
    if (!in_ready) check("not_ready_means_full", exp_q.size(), STAGES);
    if (out_ready) check("ready_passthrough", in_ready, 1);
    if (rst) begin
      exp_q.delete();
      m_have = 0; m_err = 0; m_cnt = 0; stall_prev = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_extra: got word %0d, expected none (cycle %0d)", data_out, cycle);
        end else begin
          w = exp_q.pop_front();
          check("out_data", data_out, w.d);
          check("out_mode", mode_out, w.m);
          check("latency_ok", (cycle - w.c) >= STAGES, 1);
          n_out++;
        end
      end
      stall_prev = out_valid && !out_ready;
      stall_data = data_out;
      stall_mode = mode_out;
      if (in_valid && in_ready) begin
        last_acc = 1;
        w.m = mode_in;
        w.d = mode_in ? ref_b2g(data_in) : ref_g2b(data_in);
        w.c = cycle;
        exp_q.push_back(w);
        if (!mode_in) begin
          if (m_have && hamming(data_in, m_prev) > 1) viol = 1;
          m_prev = data_in;
          m_have = 1;
        end
      end
      if (chk_clr) begin
        m_err = viol;
        m_cnt = viol ? 1 : 0;
      end else if (viol) begin
        m_err = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; chk_clr = 0;
    tick();
    rst = 0;
  endtask

  task automatic drain();
    in_valid = 0; out_ready = 1; chk_clr = 0;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  vec_t vecs[6];
  int base;
  logic [WIDTH-1:0] g;
  int idx;

  initial begin
    rst = 1; in_valid = 0; out_ready = 1; mode_in = 0; data_in = '0; chk_clr = 0;
    tick();
    tick();
    check("rst_out_valid", s_out_valid, 0);
    check("rst_data", s_data, 0);
    check("rst_in_ready", s_in_ready, 1);
    rst = 0;

    vecs[0] = '{1'b0, 5'b11000, 5'b10000};
    vecs[1] = '{1'b1, 5'd16,    5'b11000};
    vecs[2] = '{1'b0, 5'b11111, 5'b10101};
    vecs[3] = '{1'b1, 5'd21,    5'b11111};
    vecs[4] = '{1'b0, 5'b00000, 5'b00000};
    vecs[5] = '{1'b1, 5'd31,    5'b10000};
    foreach (vecs[v]) begin
      in_valid = 1; mode_in = vecs[v].mode; data_in = vecs[v].din;
      tick();
      check("vec_accept", s_in_ready, 1);
      in_valid = 0;
      for (int k = 1; k <= STAGES; k++) begin
        tick();
        if (k < STAGES) check("vec_early_valid", s_out_valid, 0);
        else begin
          check("vec_valid", s_out_valid, 1);
          check("vec_data", s_data, vecs[v].dexp);
          check("vec_mode", s_mode, vecs[v].mode);
        end
      end
    end
    drain();

    // Full Gray sequence plus wrap, back to back.
    do_reset();
    base = n_out;
    mode_in = 0; out_ready = 1;
    for (int i = 0; i <= 32; i++) begin
      in_valid = 1;
      data_in = ref_b2g(WIDTH'(i % 32));
      tick();
      check("stream_ready", s_in_ready, 1);
    end
    in_valid = 0;
    for (int k = 0; k < STAGES; k++) tick();
    check("stream_count", n_out - base, 33);
    check("stream_no_err", step_err, 0);
    drain();

    // Backpressure: slots fill, then release.
    base = n_out;
    out_ready = 0; in_valid = 1; mode_in = 1; data_in = 5'd3;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_in_ready", s_in_ready, (i < 2) ? 1 : 0);
      if (last_acc) data_in = data_in + 5'd1;
    end
    in_valid = 0; out_ready = 1;
    for (int k = 0; k < STAGES; k++) tick();
    check("bp_count", n_out - base, 2);
    drain();

    // Checker: 00000 then 00011, then a binary word, then clear.
    do_reset();
    in_valid = 1; mode_in = 0; data_in = 5'b00000; tick();
    data_in = 5'b00011; tick();
    in_valid = 0; tick();
    check("chk_err_set", s_step_err, 1);
    check("chk_cnt_one", s_err_cnt, 1);
    in_valid = 1; mode_in = 1; data_in = 5'b11111; tick();
    in_valid = 0; tick();
    check("chk_bin_err", s_step_err, 1);
    check("chk_bin_cnt", s_err_cnt, 1);
    chk_clr = 1; tick();
    chk_clr = 0; tick();
    check("chk_clr_err", s_step_err, 0);
    check("chk_clr_cnt", s_err_cnt, 0);
    drain();

    // Saturation, then clear coinciding with a violation.
    in_valid = 1; mode_in = 0;
    for (int i = 0; i < 300; i++) begin
      data_in = (i % 2) ? 5'b00011 : 5'b00000;
      tick();
    end
    in_valid = 0; tick();
    check("sat_cnt", s_err_cnt, 255);
    check("sat_err", s_step_err, 1);
    in_valid = 1; data_in = 5'b00000; chk_clr = 1; tick();
    in_valid = 0; chk_clr = 0; tick();
    check("clr_viol_cnt", s_err_cnt, 1);
    check("clr_viol_err", s_step_err, 1);
    drain();

    // Reset with two words in flight.
    in_valid = 1; mode_in = 0;
    for (int i = 5; i < 8; i++) begin
      data_in = ref_b2g(WIDTH'(i));
      tick();
    end
    check("pre_rst_cnt_nonzero", s_err_cnt != 0, 1);
    rst = 1; data_in = ref_b2g(WIDTH'(8)); tick();
    rst = 0; in_valid = 0; tick();
    check("mid_rst_valid", s_out_valid, 0);
    check("mid_rst_data", s_data, 0);
    check("mid_rst_cnt", s_err_cnt, 0);
    check("mid_rst_err", s_step_err, 0);
    in_valid = 1; data_in = 5'b10101; tick();
    in_valid = 0; tick();
    check("first_gray_no_err", s_step_err, 0);
    drain();

    // Randomized traffic against the scoreboard.
    idx = 0;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      chk_clr = ($urandom_range(0, 29) == 0);
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      mode_in = ($urandom_range(0, 3) == 0);
      idx = idx + $urandom_range(0, 2);
      g = ref_b2g(WIDTH'(idx));
      data_in = ($urandom_range(0, 7) == 0) ? WIDTH'($urandom) : g;
      tick();
    end
    rst = 0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
